// File: rtl/rs_compact_queue.sv
// Compacting reservation station: slot 0 holds the oldest entry, the oldest ready entry issues,
// and writeback tag broadcasts wake waiting operands, including on the entry being inserted.
package ooop_types;
    localparam int PREG_W = 7;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] prs1;
        logic              prs1_ready;
        logic              rs1_used;
        logic [PREG_W-1:0] prs2;
        logic              prs2_ready;
        logic              rs2_used;
        logic [5:0]        rob_idx;
        logic [7:0]        opcode;
        logic [31:0]       imm;
    } rs_entry_t;
endpackage

module rs_compact_queue_chk (
    input logic clk,
    input logic rst,
    input logic insert_valid,
    input logic ready,
    input logic flush
);
    insert_when_full: assert property (@(posedge clk) disable iff (rst)
        !(insert_valid && !ready && !flush))
        else $error("rs_compact_queue: insert presented while full was dropped");
endmodule

module rs_compact_queue
    import ooop_types::*;
#(
    parameter int DEPTH          = 8,
    parameter int PREG_W         = ooop_types::PREG_W,
    parameter int N_WB           = 2,
    parameter bit PROTOCOL_CHECK = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       insert_valid_i,
    input  rs_entry_t                  insert_entry_i,
    output logic                       ready_o,
    input  logic [N_WB-1:0]            wb_valid_i,
    input  logic [N_WB*PREG_W-1:0]     wb_tag_i,
    output logic                       issue_valid_o,
    input  logic                       issue_ready_i,
    output rs_entry_t                  issue_entry_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    rs_entry_t       slots_r     [DEPTH];
    rs_entry_t       slots_nxt_s [DEPTH];
    logic [CW-1:0]   count_r;
    logic [DEPTH-1:0] rdy_s;
    logic            any_rdy_s;
    logic [IW-1:0]   sel_s;
    logic            fire_s;
    logic            accept_s;
    logic [CW-1:0]   ins_idx_s;
    rs_entry_t       ins_entry_s;

    function automatic rs_entry_t wake(input rs_entry_t e,
                                       input logic [N_WB-1:0] v,
                                       input logic [N_WB*PREG_W-1:0] tags);
        rs_entry_t r;
        r = e;
        for (int k = 0; k < N_WB; k++) begin
            r.prs1_ready = r.prs1_ready | (v[k] & e.rs1_used & (e.prs1 == tags[k*PREG_W +: PREG_W]));
            r.prs2_ready = r.prs2_ready | (v[k] & e.rs2_used & (e.prs2 == tags[k*PREG_W +: PREG_W]));
        end
        return r;
    endfunction

    // Per-slot readiness and oldest-ready select, from registered state only.
    always_comb begin
        rdy_s = '0;
        sel_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy_s[i] = (CW'(i) < count_r)
                     & (~slots_r[i].rs1_used | slots_r[i].prs1_ready)
                     & (~slots_r[i].rs2_used | slots_r[i].prs2_ready);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            sel_s = rdy_s[i] ? IW'(i) : sel_s;
        end
        any_rdy_s = |rdy_s;
    end

    assign ready_o       = (count_r != CW'(DEPTH));
    assign count_o       = count_r;
    assign issue_valid_o = any_rdy_s & ~flush_i;
    assign issue_entry_o = issue_valid_o ? slots_r[sel_s] : '0;
    assign fire_s        = issue_valid_o & issue_ready_i;
    assign accept_s      = insert_valid_i & ready_o & ~flush_i;
    assign ins_idx_s     = fire_s ? (count_r - CW'(1)) : count_r;

    // Next slot contents: close the gap left by an issue, place the insert, then apply wakeup.
    always_comb begin
        rs_entry_t src_v;
        ins_entry_s       = insert_entry_i;
        ins_entry_s.valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            src_v = (fire_s && (IW'(i) >= sel_s)) ? slots_r[(i + 1) % DEPTH] : slots_r[i];
            src_v = (accept_s && (CW'(i) == ins_idx_s)) ? ins_entry_s : src_v;
            slots_nxt_s[i] = wake(src_v, wb_valid_i, wb_tag_i);
        end
    end

    // Slot storage and occupancy; flush only needs to empty the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            slots_r <= '{default: '0};
        end else if (flush_i) begin
            count_r <= '0;
            slots_r <= slots_r;
        end else begin
            count_r <= count_r + CW'(accept_s) - CW'(fire_s);
            slots_r <= slots_nxt_s;
        end
    end

    generate
        if (PROTOCOL_CHECK) begin : g_chk
            rs_compact_queue_chk u_chk (
                .clk          (clk),
                .rst          (rst),
                .insert_valid (insert_valid_i),
                .ready        (ready_o),
                .flush        (flush_i)
            );
        end
    endgenerate
endmodule

// File: tb/tb_rs_compact_queue.sv
// Scoreboard bench for rs_compact_queue: a queue-based reference model predicts each cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_rs_compact_queue;
    import ooop_types::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        insert_valid_i = 1'b0;
    rs_entry_t   insert_entry_i = '0;
    logic        ready_o;
    logic [1:0]  wb_valid_i = 2'b00;
    logic [13:0] wb_tag_i = 14'h0;
    logic        issue_valid_o;
    logic        issue_ready_i = 1'b0;
    rs_entry_t   issue_entry_o;
    logic [3:0]  count_o;

    typedef struct {
        logic [3:0] count;
        logic       ready;
        logic       iv;
        rs_entry_t  ent;
    } exp_t;

    exp_t      exp_q[$];
    rs_entry_t mq[$];
    int        errors = 0;
    int        checks = 0;
    int        next_id = 0;

    always #5 clk = ~clk;

    rs_compact_queue #(.DEPTH(DEPTH), .PREG_W(7), .N_WB(2), .PROTOCOL_CHECK(1'b0)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .insert_valid_i (insert_valid_i),
        .insert_entry_i (insert_entry_i),
        .ready_o        (ready_o),
        .wb_valid_i     (wb_valid_i),
        .wb_tag_i       (wb_tag_i),
        .issue_valid_o  (issue_valid_o),
        .issue_ready_i  (issue_ready_i),
        .issue_entry_o  (issue_entry_o),
        .count_o        (count_o)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic bit op_ok(input rs_entry_t e);
        return (!e.rs1_used || e.prs1_ready) && (!e.rs2_used || e.prs2_ready);
    endfunction

    function automatic rs_entry_t m_wake(input rs_entry_t e, input logic [1:0] v, input logic [13:0] t);
        logic [13:0] tv;
        tv = t;
        for (int k = 0; k < 2; k++) begin
            if (v[k] && e.rs1_used && e.prs1 == tv[k*7 +: 7]) e.prs1_ready = 1'b1;
            if (v[k] && e.rs2_used && e.prs2 == tv[k*7 +: 7]) e.prs2_ready = 1'b1;
        end
        return e;
    endfunction

    function automatic rs_entry_t mk(input logic [6:0] p1, input logic u1, input logic r1,
                                     input logic [6:0] p2, input logic u2, input logic r2);
        rs_entry_t e;
        e.valid      = 1'($urandom);
        e.prd        = 7'($urandom);
        e.prs1       = p1;
        e.rs1_used   = u1;
        e.prs1_ready = r1;
        e.prs2       = p2;
        e.rs2_used   = u2;
        e.prs2_ready = r2;
        e.rob_idx    = 6'(next_id);
        e.opcode     = 8'($urandom);
        e.imm        = $urandom;
        next_id++;
        return e;
    endfunction

    // One clock cycle: drive inputs, predict outputs, advance the model, step past the edge.
    task automatic cycle(input logic fl, input logic iv, input rs_entry_t ie,
                         input logic [1:0] wv, input logic [13:0] wt, input logic ir);
        exp_t      x;
        int        sel;
        logic      fire;
        logic      acc;
        rs_entry_t ne;
        flush_i = fl; insert_valid_i = iv; insert_entry_i = ie;
        wb_valid_i = wv; wb_tag_i = wt; issue_ready_i = ir;
        sel = -1;
        for (int i = 0; i < mq.size(); i++) if (sel < 0 && op_ok(mq[i])) sel = i;
        x.count = 4'(mq.size());
        x.ready = (mq.size() < DEPTH);
        x.iv    = (sel >= 0) && !fl;
        x.ent   = '0;
        if (x.iv) x.ent = mq[sel];
        exp_q.push_back(x);
        fire = x.iv && ir;
        acc  = iv && x.ready && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i], wv, wt);
            if (fire) mq.delete(sel);
            if (acc) begin
                ne = ie;
                ne.valid = 1'b1;
                mq.push_back(m_wake(ne, wv, wt));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic ir);
        cycle(1'b0, 1'b0, '0, 2'b00, 14'h0, ir);
    endtask

    task automatic ins(input rs_entry_t e, input logic ir);
        cycle(1'b0, 1'b1, e, 2'b00, 14'h0, ir);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("count_o", 128'(count_o), 128'(x.count));
                chk("ready_o", 128'(ready_o), 128'(x.ready));
                chk("issue_valid_o", 128'(issue_valid_o), 128'(x.iv));
                chk("issue_entry_o", 128'(issue_entry_o), 128'(x.ent));
            end
        end
    end

    initial begin : stimulus
        rs_entry_t e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wb_valid_i = 2'b11;
        wb_tag_i   = 14'($urandom);
        #1;
        chk("reset_count", 128'(count_o), 128'(4'd0));
        chk("reset_ready", 128'(ready_o), 128'(1'b1));
        chk("reset_issue_valid", 128'(issue_valid_o), 128'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Empty station never issues, whatever is broadcast.
        cycle(1'b0, 1'b0, '0, 2'b11, 14'($urandom), 1'b1);
        cycle(1'b0, 1'b0, '0, 2'b11, 14'($urandom), 1'b1);

        // In-order issue of three ready entries after a stall.
        for (int i = 0; i < 3; i++) ins(mk(7'h1, 1'b1, 1'b1, 7'h2, 1'b1, 1'b1), 1'b0);
        repeat (3) idle(1'b0);
        repeat (4) idle(1'b1);

        // Insert-cycle bypass on port 1, then a later wakeup on port 0.
        cycle(1'b0, 1'b1, mk(7'h12, 1'b1, 1'b0, 7'h0, 1'b0, 1'b0), 2'b10, {7'h12, 7'h00}, 1'b0);
        idle(1'b1);
        ins(mk(7'h0, 1'b0, 1'b0, 7'h20, 1'b1, 1'b0), 1'b1);
        repeat (2) idle(1'b1);
        cycle(1'b0, 1'b0, '0, 2'b01, {7'h00, 7'h20}, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Younger ready entry overtakes an older waiting one.
        ins(mk(7'h05, 1'b1, 1'b0, 7'h0, 1'b0, 1'b0), 1'b0);
        ins(mk(7'h06, 1'b1, 1'b1, 7'h0, 1'b0, 1'b0), 1'b0);
        idle(1'b1);
        idle(1'b0);
        cycle(1'b0, 1'b0, '0, 2'b01, {7'h00, 7'h05}, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Full boundary: drop at full, then issue+insert at count 7.
        for (int i = 0; i < DEPTH; i++) ins(mk(7'h3, 1'b1, 1'b1, 7'h4, 1'b0, 1'b0), 1'b0);
        ins(mk(7'h3, 1'b1, 1'b1, 7'h4, 1'b0, 1'b0), 1'b0);
        idle(1'b1);
        ins(mk(7'h3, 1'b1, 1'b1, 7'h4, 1'b0, 1'b0), 1'b1);
        repeat (DEPTH) idle(1'b1);

        // Flush outranks insert and issue.
        for (int i = 0; i < 5; i++) ins(mk(7'h7, 1'b1, 1'b1, 7'h8, 1'b0, 1'b0), 1'b0);
        cycle(1'b1, 1'b1, mk(7'h7, 1'b1, 1'b1, 7'h8, 1'b0, 1'b0), 2'b11, 14'($urandom), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset in the middle of a clock period.
        for (int i = 0; i < 3; i++) ins(mk(7'h9, 1'b1, 1'b1, 7'h0, 1'b0, 1'b0), 1'b0);
        flush_i = 1'b0; insert_valid_i = 1'b0; issue_ready_i = 1'b0; wb_valid_i = 2'b00;
        rst = 1'b1;
        #1;
        chk("async_reset_count", 128'(count_o), 128'(4'd0));
        chk("async_reset_ready", 128'(ready_o), 128'(1'b1));
        chk("async_reset_issue_valid", 128'(issue_valid_o), 128'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        ins(mk(7'ha, 1'b1, 1'b1, 7'h0, 1'b0, 1'b0), 1'b0);
        idle(1'b1);

        // Randomized traffic with small tag space so wakeups collide often.
        for (int n = 0; n < 3000; n++) begin
            e = mk(7'($urandom_range(0, 15)), 1'($urandom), ($urandom_range(0, 3) == 0),
                   7'($urandom_range(0, 15)), 1'($urandom), ($urandom_range(0, 3) == 0));
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), e,
                  2'($urandom), {7'($urandom_range(0, 15)), 7'($urandom_range(0, 15))},
                  ($urandom_range(0, 3) != 0));
        end
        idle(1'b0);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
